// File: rtl/sram_sched_pkg.sv
// Shared encodings for the SRAM turn scheduler: FSM states,
// requester IDs and default ROM shadow geometry.
package sram_sched_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETUP   = 2'd1;
   localparam logic [1:0] ST_STROBE  = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

   typedef enum logic [1:0] {
      RQ_VID  = 2'd0,
      RQ_BOOT = 2'd1,
      RQ_CPU  = 2'd2
   } req_id_e;

   typedef logic [2:0] gnt_t;

   localparam int unsigned DEF_ADDR_W   = 19;
   localparam logic [18:0] DEF_ROM_BASE = 19'h40000;
   localparam int unsigned DEF_ROM_LEN  = 32768;

endpackage

// File: rtl/sram_fixed_prio_arb.sv
// Combinational fixed-priority arbiter: video > boot > cpu,
// with per-requester eligibility gating; one-hot grant out.
module sram_fixed_prio_arb
   import sram_sched_pkg::*;
(
   input  logic i_vid_req,
   input  logic i_boot_req,
   input  logic i_cpu_req,
   input  logic i_boot_elig,
   input  logic i_cpu_elig,
   output gnt_t o_gnt
);

   logic w_boot;
   logic w_cpu;

   assign w_boot = i_boot_req & i_boot_elig;
   assign w_cpu  = i_cpu_req & i_cpu_elig;

   always_comb begin
      o_gnt = '0;
      if (i_vid_req) begin
         o_gnt[RQ_VID] = 1'b1;
      end else if (w_boot) begin
         o_gnt[RQ_BOOT] = 1'b1;
      end else if (w_cpu) begin
         o_gnt[RQ_CPU] = 1'b1;
      end
   end

endmodule

// File: rtl/sram_turn_scheduler.sv
// Three-cycle SRAM access sequencer shared by video, boot loader and CPU.
// Optional SRAM_ROM_WRPROT_EN makes the ROM shadow read-only to the CPU.
module sram_turn_scheduler
   import sram_sched_pkg::*;
#(
   parameter int unsigned        ADDR_W   = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0]  ROM_BASE = ADDR_W'(DEF_ROM_BASE),
   parameter int unsigned        ROM_LEN  = DEF_ROM_LEN
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [7:0]        vid_data,
   output logic              vid_valid,
   input  logic              cpu_req,
   input  logic              cpu_we_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   input  logic              boot_req,
   input  logic [7:0]        boot_wdata,
   output logic              boot_ack,
   output logic              rom_initialised,
   output logic [ADDR_W-1:0] sram_a,
   output logic [7:0]        sram_dout,
   input  logic [7:0]        sram_din,
   output logic              sram_d_oe,
   output logic              sram_we_n
);

   localparam int unsigned     CNT_W    = $clog2(ROM_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LEN - 1);

   logic [1:0]        r_state;
   gnt_t              r_win;
   logic              r_wr;
   logic              r_cpu_wr;
   logic [ADDR_W-1:0] r_a;
   logic [7:0]        r_dout;
   logic              r_oe;
   logic              r_we_n;
   logic [7:0]        r_vid_data;
   logic              r_vid_valid;
   logic [7:0]        r_cpu_rdata;
   logic              r_cpu_ack;
   logic              r_boot_ack;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_done;
   logic              r_rom_init;

   gnt_t              w_gnt;
   logic              w_any;
   logic              w_prot;
   logic              w_wr;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_wdata;

   // r_done flags the final boot byte one cycle before rom_initialised,
   // so the arbiter never re-grants boot during that last ack cycle.
   sram_fixed_prio_arb u_arb (
      .i_vid_req   (vid_req),
      .i_boot_req  (boot_req),
      .i_cpu_req   (cpu_req),
      .i_boot_elig (~r_done),
      .i_cpu_elig  (r_rom_init),
      .o_gnt       (w_gnt)
   );

   assign w_any = |w_gnt;

`ifdef SRAM_ROM_WRPROT_EN
   localparam logic [ADDR_W:0] ROM_END =
      {1'b0, ROM_BASE} + (ADDR_W+1)'(ROM_LEN);
   assign w_prot = (cpu_addr >= ROM_BASE) &&
                   ({1'b0, cpu_addr} < ROM_END);
`else
   assign w_prot = 1'b0;
`endif

   always_comb begin
      w_addr  = vid_addr;
      w_wdata = 8'h00;
      w_wr    = 1'b0;
      unique case (1'b1)
         w_gnt[RQ_BOOT]: begin
            w_addr  = ROM_BASE + ADDR_W'(r_cnt);
            w_wdata = boot_wdata;
            w_wr    = 1'b1;
         end
         w_gnt[RQ_CPU]: begin
            w_addr  = cpu_addr;
            w_wdata = cpu_wdata;
            w_wr    = ~cpu_we_n & ~w_prot;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_win       <= '0;
         r_wr        <= 1'b0;
         r_cpu_wr    <= 1'b0;
         r_a         <= '0;
         r_dout      <= 8'h00;
         r_oe        <= 1'b0;
         r_we_n      <= 1'b1;
         r_vid_data  <= 8'h00;
         r_vid_valid <= 1'b0;
         r_cpu_rdata <= 8'h00;
         r_cpu_ack   <= 1'b0;
         r_boot_ack  <= 1'b0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_rom_init  <= 1'b0;
      end else begin
         r_vid_valid <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_boot_ack  <= 1'b0;
         r_rom_init  <= r_done;
         unique case (r_state)
            ST_IDLE, ST_CAPTURE: begin
               r_we_n <= 1'b1;
               r_oe   <= 1'b0;
               if (w_any) begin
                  r_state  <= ST_SETUP;
                  r_win    <= w_gnt;
                  r_wr     <= w_wr;
                  r_cpu_wr <= w_gnt[RQ_CPU] & ~cpu_we_n;
                  r_a      <= w_addr;
                  r_dout   <= w_wdata;
                  r_oe     <= w_wr;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               r_we_n  <= ~r_wr;
               r_state <= ST_STROBE;
            end
            ST_STROBE: begin
               r_we_n  <= 1'b1;
               r_oe    <= 1'b0;
               r_state <= ST_CAPTURE;
               if (r_win[RQ_VID]) begin
                  r_vid_data  <= sram_din;
                  r_vid_valid <= 1'b1;
               end
               if (r_win[RQ_CPU]) begin
                  r_cpu_ack <= 1'b1;
                  if (!r_cpu_wr) r_cpu_rdata <= sram_din;
               end
               if (r_win[RQ_BOOT]) begin
                  r_boot_ack <= 1'b1;
                  if (r_cnt == CNT_LAST) r_done <= 1'b1;
                  else                   r_cnt  <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign vid_data        = r_vid_data;
   assign vid_valid       = r_vid_valid;
   assign cpu_rdata       = r_cpu_rdata;
   assign cpu_ack         = r_cpu_ack;
   assign boot_ack        = r_boot_ack;
   assign rom_initialised = r_rom_init;
   assign sram_a          = r_a;
   assign sram_dout       = r_dout;
   assign sram_d_oe       = r_oe;
   assign sram_we_n       = r_we_n;

endmodule

// File: tb/tb_sram_turn_scheduler.sv
// Directed bench for sram_turn_scheduler with a behavioural SRAM;
// uses a shortened ROM image so the boot fill stays short.
module tb_sram_turn_scheduler;

   localparam int          ROM_LEN  = 256;
   localparam logic [18:0] ROM_BASE = 19'h40000;

   logic        clk;
   logic        rst_n;
   logic        vid_req;
   logic [18:0] vid_addr;
   logic [7:0]  vid_data;
   logic        vid_valid;
   logic        cpu_req;
   logic        cpu_we_n;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        boot_req;
   logic [7:0]  boot_wdata;
   logic        boot_ack;
   logic        rom_initialised;
   logic [18:0] sram_a;
   logic [7:0]  sram_dout;
   logic [7:0]  sram_din;
   logic        sram_d_oe;
   logic        sram_we_n;

   logic [7:0] mem [0:524287];

   int n_chk;
   int n_pass;

   sram_turn_scheduler #(.ROM_LEN(ROM_LEN)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .vid_req         (vid_req),
      .vid_addr        (vid_addr),
      .vid_data        (vid_data),
      .vid_valid       (vid_valid),
      .cpu_req         (cpu_req),
      .cpu_we_n        (cpu_we_n),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_rdata       (cpu_rdata),
      .cpu_ack         (cpu_ack),
      .boot_req        (boot_req),
      .boot_wdata      (boot_wdata),
      .boot_ack        (boot_ack),
      .rom_initialised (rom_initialised),
      .sram_a          (sram_a),
      .sram_dout       (sram_dout),
      .sram_din        (sram_din),
      .sram_d_oe       (sram_d_oe),
      .sram_we_n       (sram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous SRAM: combinational read, write while we_n is low.
   assign sram_din = mem[sram_a];
   always @(negedge clk) begin
      if (!sram_we_n) mem[sram_a] <= sram_dout;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic cpu_xfer(input logic we_n, input logic [18:0] addr,
                           input logic [7:0] wd, output logic [7:0] rd,
                           output int lat, output int lo);
      bit done;
      cpu_we_n  = we_n;
      cpu_addr  = addr;
      cpu_wdata = wd;
      cpu_req   = 1'b1;
      lat  = 0;
      lo   = 0;
      rd   = 8'h00;
      done = 1'b0;
      for (int n = 1; n <= 40 && !done; n++) begin
         @(negedge clk);
         if (!sram_we_n) lo++;
         if (n == 1) chk("cpu_setup_addr", sram_a, addr);
         if (cpu_ack) begin
            done    = 1'b1;
            lat     = n;
            rd      = cpu_rdata;
            cpu_req = 1'b0;
         end
      end
      if (!done) begin
         chk("cpu_ack_timeout", 0, 1);
         cpu_req = 1'b0;
      end
   endtask

   int         idx, cyc, last, acks, lo, lat, cv, cc, exp_lo, blat;
   logic [18:0] wa, ba;
   logic [7:0]  wd, rd, vd, exp_rb;

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      vid_req = 1'b0;
      vid_addr = '0;
      cpu_req = 1'b0;
      cpu_we_n = 1'b1;
      cpu_addr = '0;
      cpu_wdata = '0;
      boot_req = 1'b0;
      boot_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_d_oe", sram_d_oe, 0);
      chk("rst_a", sram_a, 0);
      chk("rst_dout", sram_dout, 0);
      chk("rst_rom_init", rom_initialised, 0);
      chk("rst_acks", {vid_valid, cpu_ack, boot_ack}, 0);
      chk("rst_rdata", {vid_data, cpu_rdata}, 0);
      rst_n = 1'b1;

      // CPU is stalled until the ROM image is loaded
      cpu_we_n = 1'b1;
      cpu_addr = 19'h40005;
      cpu_req  = 1'b1;
      acks = 0;
      lo = 0;
      repeat (100) begin
         @(negedge clk);
         if (cpu_ack) acks++;
         if (!sram_we_n) lo++;
      end
      chk("cpu_stall_ack", acks, 0);
      chk("cpu_stall_we", lo, 0);
      cpu_req = 1'b0;

      idx = 0;
      cyc = 0;
      last = 0;
      wa = '0;
      wd = '0;
      boot_wdata = 8'h00;
      boot_req = 1'b1;
      while (idx < ROM_LEN && cyc < 4 * ROM_LEN + 50) begin
         @(negedge clk);
         cyc++;
         if (!sram_we_n) begin
            wa = sram_a;
            wd = sram_dout;
         end
         if (boot_ack) begin
            chk("boot_addr", wa, ROM_BASE + 19'(idx));
            chk("boot_data", wd, idx & 255);
            if (idx > 0) chk("boot_gap", cyc - last, 3);
            if (idx == ROM_LEN - 1)
               chk("init_early", rom_initialised, 0);
            last = cyc;
            idx++;
            boot_wdata = 8'(idx);
         end
      end
      chk("boot_count", idx, ROM_LEN);
      @(negedge clk);
      chk("rom_init_rise", rom_initialised, 1);
      acks = 0;
      repeat (30) begin
         @(negedge clk);
         if (boot_ack) acks++;
      end
      chk("boot_after_init", acks, 0);
      chk("rom_init_sticky", rom_initialised, 1);
      boot_req = 1'b0;
      @(negedge clk);

      cpu_xfer(1'b1, 19'h40005, 8'h00, rd, lat, lo);
      chk("rom_rd_data", rd, 8'h05);
      chk("rom_rd_lat", lat, 3);

      cpu_xfer(1'b0, 19'h00010, 8'hA5, rd, lat, lo);
      chk("wr_we_cycles", lo, 1);
      chk("wr_lat", lat, 3);
      chk("rdata_hold", cpu_rdata, 8'h05);
      cpu_xfer(1'b1, 19'h00010, 8'h00, rd, lat, lo);
      chk("wr_readback", rd, 8'hA5);

      // video and CPU request in the same cycle
      vid_addr = 19'h40007;
      vid_req = 1'b1;
      cpu_we_n = 1'b1;
      cpu_addr = 19'h00010;
      cpu_req = 1'b1;
      cv = -1;
      cc = -1;
      vd = '0;
      for (int n = 1; n <= 40 && cc < 0; n++) begin
         @(negedge clk);
         if (vid_valid) begin
            cv = n;
            vd = vid_data;
            vid_req = 1'b0;
         end
         if (cpu_ack) begin
            cc = n;
            rd = cpu_rdata;
            cpu_req = 1'b0;
         end
      end
      vid_req = 1'b0;
      cpu_req = 1'b0;
      chk("vid_first_lat", cv, 3);
      chk("vid_data", vd, 8'h07);
      chk("cpu_after_vid", cc - cv, 3);
      chk("cpu_after_vid_data", rd, 8'hA5);

`ifdef SRAM_ROM_WRPROT_EN
      exp_lo = 0;
      exp_rb = 8'h05;
`else
      exp_lo = 1;
      exp_rb = 8'h00;
`endif
      cpu_xfer(1'b0, 19'h40005, 8'h00, rd, lat, lo);
      chk("rom_wr_lat", lat, 3);
      chk("rom_wr_we_cycles", lo, exp_lo);
      cpu_xfer(1'b1, 19'h40005, 8'h00, rd, lat, lo);
      chk("rom_wr_readback", rd, exp_rb);

      // reset during the strobe cycle of a write
      cpu_we_n = 1'b0;
      cpu_addr = 19'h00020;
      cpu_wdata = 8'h5A;
      cpu_req = 1'b1;
      @(negedge clk);
      chk("mid_setup_oe", sram_d_oe, 1);
      @(negedge clk);
      chk("mid_strobe_we", sram_we_n, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_we_n", sram_we_n, 1);
      chk("async_d_oe", sram_d_oe, 0);
      chk("async_a", sram_a, 0);
      chk("async_rom_init", rom_initialised, 0);
      cpu_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_rom_init", rom_initialised, 0);
      chk("post_rst_we_n", sram_we_n, 1);

      boot_wdata = 8'h77;
      boot_req = 1'b1;
      blat = -1;
      ba = '0;
      for (int n = 1; n <= 20 && blat < 0; n++) begin
         @(negedge clk);
         if (n == 1) ba = sram_a;
         if (boot_ack) begin
            blat = n;
            boot_req = 1'b0;
         end
      end
      boot_req = 1'b0;
      chk("post_rst_boot_lat", blat, 3);
      chk("post_rst_boot_addr", ba, 19'h40000);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
